// File: rtl/axi4_rw_scheduler.sv
// Serialises AXI4 write and read bursts onto one shared slave datapath.
// Round-robin address arbitration, beat tracking, WLAST check, stall watchdog.
module axi4_rw_scheduler #(
  parameter int ID_WIDTH = 4,
  parameter int TIMEOUT  = 1024,
  parameter int TO_WIDTH = 11
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                S_AXI_AWVALID,
  input  logic [ID_WIDTH-1:0] S_AXI_AWID,
  input  logic [7:0]          S_AXI_AWLEN,
  output logic                S_AXI_AWREADY,
  input  logic                S_AXI_ARVALID,
  input  logic [ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [7:0]          S_AXI_ARLEN,
  output logic                S_AXI_ARREADY,
  input  logic                w_beat,
  input  logic                w_last,
  input  logic                b_done,
  input  logic                r_beat,
  input  logic                r_last,
  output logic                write_en,
  output logic                read_en,
  output logic [ID_WIDTH-1:0] burst_id,
  output logic [7:0]          burst_len,
  output logic [7:0]          beat_cnt,
  output logic                len_err,
  output logic                timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_AW_ACC, S_WR_DATA, S_WR_RESP, S_AR_ACC, S_RD_DATA
  } state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [7:0]          len;
  } burst_t;

  localparam logic [TO_WIDTH-1:0] WD_MAX = TO_WIDTH'(TIMEOUT - 1);

  state_t              state, state_nxt;
  burst_t              burst_q, burst_nxt;
  logic                last_wr_q, last_wr_nxt;
  logic [TO_WIDTH-1:0] wd_q, wd_nxt;
  logic [7:0]          beat_q, beat_nxt, beat_inc;
  logic                len_err_q, len_err_nxt;
  logic                timeout_q, timeout_nxt;
  logic                active, evt;

  assign beat_inc = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
  assign active   = (state == S_WR_DATA) || (state == S_WR_RESP) || (state == S_RD_DATA);
  // Anything that proves the burst is still making progress.
  assign evt      = ((state == S_WR_DATA) && w_beat) ||
                    ((state == S_WR_RESP) && b_done) ||
                    ((state == S_RD_DATA) && r_beat);

  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_q;
    last_wr_nxt = last_wr_q;
    wd_nxt      = wd_q;
    beat_nxt    = beat_q;
    len_err_nxt = 1'b0;
    timeout_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_ARVALID) begin
          state_nxt   = last_wr_q ? S_AR_ACC : S_AW_ACC;
          last_wr_nxt = !last_wr_q;
        end else if (S_AXI_AWVALID) begin
          state_nxt   = S_AW_ACC;
          last_wr_nxt = 1'b1;
        end else if (S_AXI_ARVALID) begin
          state_nxt   = S_AR_ACC;
          last_wr_nxt = 1'b0;
        end
      end
      S_AW_ACC: begin
        burst_nxt = '{id: S_AXI_AWID, len: S_AXI_AWLEN};
        beat_nxt  = '0;
        wd_nxt    = '0;
        state_nxt = S_WR_DATA;
      end
      S_AR_ACC: begin
        burst_nxt = '{id: S_AXI_ARID, len: S_AXI_ARLEN};
        beat_nxt  = '0;
        wd_nxt    = '0;
        state_nxt = S_RD_DATA;
      end
      S_WR_DATA: begin
        if (w_beat) begin
          beat_nxt = beat_inc;
          wd_nxt   = '0;
          if (w_last) begin
            state_nxt   = S_WR_RESP;
            len_err_nxt = (beat_q != burst_q.len);
          end else begin
            // Overrun: flag it but keep draining until the master sends WLAST.
            len_err_nxt = (beat_q == burst_q.len);
          end
        end
      end
      S_WR_RESP: begin
        if (b_done) begin
          state_nxt = S_IDLE;
          wd_nxt    = '0;
        end
      end
      S_RD_DATA: begin
        if (r_beat) begin
          beat_nxt = beat_inc;
          wd_nxt   = '0;
          if (r_last) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (active && !evt) begin
      if (wd_q == WD_MAX) begin
        state_nxt   = S_IDLE;
        timeout_nxt = 1'b1;
        beat_nxt    = '0;
        wd_nxt      = '0;
      end else begin
        wd_nxt = wd_q + TO_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= S_IDLE;
      burst_q   <= '0;
      last_wr_q <= 1'b1;
      wd_q      <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_q   <= burst_nxt;
      last_wr_q <= last_wr_nxt;
      wd_q      <= wd_nxt;
      beat_q    <= beat_nxt;
      len_err_q <= len_err_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Every output is a decode of, or a copy of, a flop.
  assign S_AXI_AWREADY = (state == S_AW_ACC);
  assign S_AXI_ARREADY = (state == S_AR_ACC);
  assign write_en      = (state == S_WR_DATA) || (state == S_WR_RESP);
  assign read_en       = (state == S_RD_DATA);
  assign burst_id      = burst_q.id;
  assign burst_len     = burst_q.len;
  assign beat_cnt      = beat_q;
  assign len_err       = len_err_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_axi4_rw_scheduler.sv
// Self-checking bench for axi4_rw_scheduler: vector table, corner sequences,
// and randomized bursts predicted by a transaction-level model.
module tb_axi4_rw_scheduler;
  localparam int IDW = 4;
  localparam int TO  = 8;

  logic ACLK = 1'b0;
  logic ARESET;
  logic S_AXI_AWVALID, S_AXI_ARVALID, S_AXI_AWREADY, S_AXI_ARREADY;
  logic [IDW-1:0] S_AXI_AWID, S_AXI_ARID, burst_id;
  logic [7:0] S_AXI_AWLEN, S_AXI_ARLEN, burst_len, beat_cnt;
  logic w_beat, w_last, b_done, r_beat, r_last;
  logic write_en, read_en, len_err, timeout;

  axi4_rw_scheduler #(.ID_WIDTH(IDW), .TIMEOUT(TO), .TO_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .w_beat(w_beat), .w_last(w_last), .b_done(b_done), .r_beat(r_beat), .r_last(r_last),
    .write_en(write_en), .read_en(read_en), .burst_id(burst_id), .burst_len(burst_len),
    .beat_cnt(beat_cnt), .len_err(len_err), .timeout(timeout)
  );

  always #5 ACLK = ~ACLK;

  int n_pass = 0;
  int n_chk  = 0;
  bit m_last_wr;  // model: direction of the most recent grant

  typedef struct {
    bit             wr;
    logic [IDW-1:0] id;
    logic [7:0]     len;
    int             last_at;
    int             exp_lerr;
    int             exp_en;
    int             exp_beat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clr_inputs();
    S_AXI_AWVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_AWID = '0; S_AXI_ARID = '0; S_AXI_AWLEN = '0; S_AXI_ARLEN = '0;
    w_beat = 0; w_last = 0; b_done = 0; r_beat = 0; r_last = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy"}, {S_AXI_AWREADY, S_AXI_ARREADY}, 0);
    chk({nm, "_en"}, {write_en, read_en}, 0);
    chk({nm, "_id"}, burst_id, 0);
    chk({nm, "_len"}, burst_len, 0);
    chk({nm, "_beat"}, beat_cnt, 0);
    chk({nm, "_pulses"}, {len_err, timeout}, 0);
  endtask

  task automatic do_reset();
    ARESET = 1;
    clr_inputs();
    tick();
    tick();
    ARESET = 0;
    m_last_wr = 1;
  endtask

  // IDLE cycle -> ACC cycle -> first data cycle; round-robin predicted by the model.
  task automatic grant(input bit aw, input bit ar, input logic [IDW-1:0] awid, input logic [7:0] awlen,
                       input logic [IDW-1:0] arid, input logic [7:0] arlen, output bit gw);
    gw = (aw && ar) ? !m_last_wr : aw;
    m_last_wr = gw;
    S_AXI_AWVALID = aw; S_AXI_AWID = awid; S_AXI_AWLEN = awlen;
    S_AXI_ARVALID = ar; S_AXI_ARID = arid; S_AXI_ARLEN = arlen;
    chk("idle_rdy", {S_AXI_AWREADY, S_AXI_ARREADY}, 0);
    chk("idle_en", {write_en, read_en}, 0);
    tick();
    chk("awready", S_AXI_AWREADY, gw);
    chk("arready", S_AXI_ARREADY, !gw);
    chk("acc_en", {write_en, read_en}, 0);
    tick();
    if (gw) S_AXI_AWVALID = 0; else S_AXI_ARVALID = 0;
    chk("rdy_drop", {S_AXI_AWREADY, S_AXI_ARREADY}, 0);
  endtask

  // Drives one burst's data (and B) phase; expectations come from the rules:
  // len_err on a WLAST at the wrong index or a missing WLAST at index len,
  // abort after TO consecutive cycles with no progress.
  task automatic run_burst(input bit wr, input logic [IDW-1:0] id, input logic [7:0] len,
                           input int last_at, input int maxgap, input int stall_after,
                           input int bdelay, output int lerr_cnt, output int en_cyc,
                           output bit aborted);
    int beats = 0, quiet = 0, gap = 0, cyc = 0;
    bit done = 0, beat, last, lerr_exp, to_exp;
    lerr_cnt = 0; en_cyc = 0; aborted = 0;
    chk("en_rise", wr ? write_en : read_en, 1);
    chk("en_other", wr ? read_en : write_en, 0);
    chk("start_beat", beat_cnt, 0);
    chk("lat_id", burst_id, id);
    chk("lat_len", burst_len, len);
    while (!done && cyc < 400) begin
      cyc++;
      en_cyc++;
      beat = (stall_after >= 0 && beats >= stall_after) ? 1'b0 : (gap == 0);
      if (beat) gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      else if (gap > 0) gap--;
      last = beat && (beats == last_at);
      if (wr) begin w_beat = beat; w_last = last; end
      else begin r_beat = beat; r_last = last; end
      lerr_exp = 0; to_exp = 0;
      if (beat) begin
        if (wr) lerr_exp = last ? (beats != int'(len)) : (beats == int'(len));
        if (beats < 255) beats++;
        quiet = 0;
      end else begin
        quiet++;
        if (quiet == TO) to_exp = 1;
      end
      tick();
      w_beat = 0; w_last = 0; r_beat = 0; r_last = 0;
      chk("len_err", len_err, lerr_exp);
      chk("timeout", timeout, to_exp);
      chk("rdy_quiet", {S_AXI_AWREADY, S_AXI_ARREADY}, 0);
      lerr_cnt += int'(len_err);
      if (to_exp) begin
        aborted = 1;
        chk("abort_en", {write_en, read_en}, 0);
        chk("abort_beat", beat_cnt, 0);
        done = 1;
      end else if (last && !wr) begin
        chk("rd_end", read_en, 0);
        chk("rd_beat", beat_cnt, beats);
        done = 1;
      end else begin
        chk("en_hold", wr ? write_en : read_en, 1);
        chk("beat_cnt", beat_cnt, beats);
        if (last) done = 1;
      end
    end
    if (!done) chk("burst_bound", 0, 1);
    if (wr && !aborted && done) begin
      for (int i = 0; i <= bdelay; i++) begin
        b_done = (i == bdelay);
        en_cyc++;
        tick();
        b_done = 0;
        chk("resp_pulses", {len_err, timeout}, 0);
        chk(i < bdelay ? "resp_hold" : "wr_fall", write_en, i < bdelay);
      end
      chk("wr_beat", beat_cnt, beats);
    end
  endtask

  task automatic plain_burst(input bit wr, input logic [IDW-1:0] id, input logic [7:0] len);
    int le, ec;
    bit ab;
    run_burst(wr, id, len, len, 1, -1, 1, le, ec, ab);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    bit gw, ab, pend_aw, pend_ar;
    int le, ec;
    logic [IDW-1:0] aw_id, ar_id;
    logic [7:0] aw_len, ar_len;

    tbl[0] = '{1'b1, 4'd5,  8'd3, 3, 0, 5, 4};
    tbl[1] = '{1'b1, 4'd2,  8'd3, 1, 1, 3, 2};
    tbl[2] = '{1'b1, 4'd9,  8'd1, 2, 2, 4, 3};
    tbl[3] = '{1'b0, 4'd7,  8'd0, 0, 0, 1, 1};
    tbl[4] = '{1'b0, 4'd3,  8'd2, 2, 0, 3, 3};
    tbl[5] = '{1'b1, 4'd15, 8'd0, 0, 0, 2, 1};

    do_reset();
    chk_zero("reset");

    for (int i = 0; i < 6; i++) begin
      grant(tbl[i].wr, !tbl[i].wr, tbl[i].id, tbl[i].len, tbl[i].id, tbl[i].len, gw);
      run_burst(tbl[i].wr, tbl[i].id, tbl[i].len, tbl[i].last_at, 0, -1, 0, le, ec, ab);
      chk($sformatf("vec%0d_lerr", i), le, tbl[i].exp_lerr);
      chk($sformatf("vec%0d_en_cycles", i), ec, tbl[i].exp_en);
      chk($sformatf("vec%0d_beat", i), beat_cnt, tbl[i].exp_beat);
      chk($sformatf("vec%0d_id", i), burst_id, tbl[i].id);
    end

    // Contention from reset: read first, then alternate.
    do_reset();
    grant(1, 1, 4'd1, 8'd1, 4'd2, 8'd0, gw);
    plain_burst(0, 4'd2, 8'd0);
    grant(1, 0, 4'd1, 8'd1, 4'd0, 8'd0, gw);
    plain_burst(1, 4'd1, 8'd1);
    grant(1, 1, 4'd4, 8'd0, 4'd6, 8'd1, gw);
    plain_burst(0, 4'd6, 8'd1);
    grant(1, 0, 4'd4, 8'd0, 4'd0, 8'd0, gw);
    plain_burst(1, 4'd4, 8'd0);

    // Watchdog: write with no beats, then a fresh AR must be accepted.
    grant(1, 0, 4'd8, 8'd3, 4'd0, 8'd0, gw);
    run_burst(1, 4'd8, 8'd3, 3, 0, 0, 0, le, ec, ab);
    chk("wd_aborted", ab, 1);
    chk("wd_en_cycles", ec, TO);
    grant(0, 1, 4'd0, 8'd0, 4'd11, 8'd2, gw);
    plain_burst(0, 4'd11, 8'd2);

    // Reset mid read at beat_cnt=2.
    grant(0, 1, 4'd0, 8'd0, 4'd12, 8'd5, gw);
    r_beat = 1;
    tick();
    tick();
    r_beat = 0;
    chk("mid_beat", beat_cnt, 2);
    chk("mid_rd_en", read_en, 1);
    ARESET = 1;
    tick();
    chk_zero("mid_reset");
    ARESET = 0;
    m_last_wr = 1;
    grant(1, 1, 4'd13, 8'd1, 4'd14, 8'd1, gw);
    plain_burst(0, 4'd14, 8'd1);
    grant(1, 0, 4'd13, 8'd1, 4'd0, 8'd0, gw);
    plain_burst(1, 4'd13, 8'd1);

    // Randomized traffic; a losing request stays valid until granted.
    pend_aw = 0; pend_ar = 0;
    aw_id = '0; ar_id = '0; aw_len = '0; ar_len = '0;
    for (int it = 0; it < 40; it++) begin
      int last_at, stall;
      logic [IDW-1:0] gid;
      logic [7:0] glen;
      if (!pend_aw && $urandom_range(1, 0) == 1) begin
        pend_aw = 1; aw_id = 4'($urandom_range(15, 0)); aw_len = 8'($urandom_range(5, 0));
      end
      if (!pend_ar && $urandom_range(1, 0) == 1) begin
        pend_ar = 1; ar_id = 4'($urandom_range(15, 0)); ar_len = 8'($urandom_range(5, 0));
      end
      if (!pend_aw && !pend_ar) begin
        pend_ar = 1; ar_id = 4'($urandom_range(15, 0)); ar_len = 8'($urandom_range(5, 0));
      end
      grant(pend_aw, pend_ar, aw_id, aw_len, ar_id, ar_len, gw);
      gid  = gw ? aw_id : ar_id;
      glen = gw ? aw_len : ar_len;
      if (gw) pend_aw = 0; else pend_ar = 0;
      last_at = ($urandom_range(3, 0) == 0) ? $urandom_range(int'(glen) + 2, 0) : int'(glen);
      stall   = ($urandom_range(5, 0) == 0) ? $urandom_range(int'(glen), 0) : -1;
      run_burst(gw, gid, glen, last_at, 2, stall, $urandom_range(3, 0), le, ec, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
